// File: rtl/aes_round_ctrl.sv
// AES round sequencer: loads a block, walks the external round
// datapath through NR rounds, then holds the ciphertext for handoff.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         abort,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_data,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic [3:0]   rnd_num,
  output logic         rnd_final,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [15:0]  blk_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] LP_NR = 4'(NR);

  state_t       r_st;
  logic [127:0] r_data;
  logic [3:0]   r_cnt;
  logic [15:0]  r_blk_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LP_NR);

  // Round counter parks at NR on the exit edge so it never exceeds NR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= IDLE;
      r_data    <= '0;
      r_cnt     <= '0;
      r_blk_cnt <= '0;
    end else begin
      unique case (r_st)
        IDLE: begin
          if (!abort && in_valid) begin
            r_data <= in_data ^ key_data;
            r_cnt  <= 4'd1;
            r_st   <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            r_st  <= IDLE;
            r_cnt <= '0;
          end else begin
            r_data <= rnd_result;
            if (w_last) begin
              r_st <= HOLD;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            r_st  <= IDLE;
            r_cnt <= '0;
          end else if (out_ready) begin
            r_st      <= IDLE;
            r_cnt     <= '0;
            r_blk_cnt <= r_blk_cnt + 16'd1;
          end
        end
        default: begin
          r_st  <= IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    key_idx = 4'd0;
    unique case (r_st)
      IDLE:    key_idx = 4'd0;
      ROUND:   key_idx = r_cnt;
      HOLD:    key_idx = LP_NR;
      default: key_idx = 4'd0;
    endcase
  end

  assign in_ready  = (r_st == IDLE);
  assign out_valid = (r_st == HOLD);
  assign busy      = (r_st == ROUND) || (r_st == HOLD);
  assign rnd_state = r_data;
  assign rnd_key   = key_data;
  assign rnd_num   = r_cnt;
  assign rnd_final = (r_st == ROUND) && w_last;
  assign out_data  = r_data;
  assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: real AES-128 round datapath and key
// schedule around the controller, checked against a whole-block model.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         abort;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic [3:0]   rnd_num;
  logic         rnd_final;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [15:0]  blk_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk [16];
  logic [15:0]  exp_cnt;
  logic [127:0] exp_st;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .abort      (abort),
    .key_idx    (key_idx),
    .key_data   (key_data),
    .rnd_state  (rnd_state),
    .rnd_key    (rnd_key),
    .rnd_num    (rnd_num),
    .rnd_final  (rnd_final),
    .rnd_result (rnd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .blk_cnt    (blk_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b,
                                       input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] st,
                                           input logic [127:0] k,
                                           input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        b[w+4*c] = a[w+4*((c+w)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = gmul(8'd2,c0) ^ gmul(8'd3,c1) ^ c2 ^ c3;
        b[4*c+1] = c0 ^ gmul(8'd2,c1) ^ gmul(8'd3,c2) ^ c3;
        b[4*c+2] = c0 ^ c1 ^ gmul(8'd2,c2) ^ gmul(8'd3,c3);
        b[4*c+3] = gmul(8'd3,c0) ^ c1 ^ c2 ^ gmul(8'd2,c3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  // State after n full AES rounds applied on top of the whitening key.
  function automatic logic [127:0] enc_part(input logic [127:0] pt,
                                            input int n);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= n; r++) s = aes_rnd(s, rk[r], r == NR);
    return s;
  endfunction

  assign key_data   = rk[key_idx];
  assign rnd_result = aes_rnd(rnd_state, rnd_key, rnd_final);

  task automatic build_sbox();
    logic [7:0] p;
    for (int i = 0; i < 256; i++) begin
      p = 8'h01;
      if (i == 0) p = 8'h00;
      else repeat (254) p = gmul(p, 8'(i));
      sb[i] = p ^ rotl8(p,1) ^ rotl8(p,2) ^ rotl8(p,3)
                ^ rotl8(p,4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= NR; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after handoff.
  task automatic run_block(input logic [127:0] pt,
                           input int hold, input bit b2b);
    logic [127:0] ct;
    ct = enc_part(pt, NR);
    chk("ir_idle", 128'(in_ready), 128'(1));
    chk("key0", 128'(key_idx), 128'(0));
    in_valid = 1'b1;
    in_data  = pt;
    @(negedge clk);
    if (b2b) chk("spacing", 128'(cyc - last_acc), 128'(NR + 2));
    last_acc = cyc;
    for (int k = 1; k <= NR; k++) begin
      chk("key_idx", 128'(key_idx), 128'(k));
      chk("rnd_num", 128'(rnd_num), 128'(k));
      chk("rnd_final", 128'(rnd_final), 128'(k == NR));
      chk("ov_round", 128'(out_valid), 128'(0));
      chk("busy_round", 128'(busy), 128'(1));
      in_valid = 1'($urandom);
      in_data  = rnd128();
      @(negedge clk);
    end
    chk("latency_ov", 128'(out_valid), 128'(1));
    chk("out_data", out_data, ct);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      in_data   = rnd128();
      @(negedge clk);
      chk("bp_ov", 128'(out_valid), 128'(1));
      chk("bp_data", out_data, ct);
      chk("bp_ir", 128'(in_ready), 128'(0));
      chk("bp_busy", 128'(busy), 128'(1));
      chk("bp_cnt", 128'(blk_cnt), 128'(exp_cnt));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = rnd128();
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    exp_st  = ct;
    chk("hs_ov", 128'(out_valid), 128'(0));
    chk("hs_ir", 128'(in_ready), 128'(1));
    chk("hs_cnt", 128'(blk_cnt), 128'(exp_cnt));
    chk("hs_noacc", rnd_state, exp_st);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic run_abort(input logic [127:0] pt, input int at);
    in_valid = 1'b1;
    in_data  = pt;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k < at; k++) @(negedge clk);
    exp_st = enc_part(pt, at - 1);
    chk("ab_rnd", 128'(rnd_num), 128'(at));
    chk("ab_pre", rnd_state, exp_st);
    abort    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("ab_ir", 128'(in_ready), 128'(1));
    chk("ab_busy", 128'(busy), 128'(0));
    chk("ab_ov", 128'(out_valid), 128'(0));
    chk("ab_cnt", 128'(blk_cnt), 128'(exp_cnt));
    chk("ab_state", rnd_state, exp_st);
    @(negedge clk);
    chk("ab_ov2", 128'(out_valid), 128'(0));
    chk("ab_ir2", 128'(in_ready), 128'(1));
  endtask

  task automatic abort_hold(input logic [127:0] pt);
    in_valid = 1'b1;
    in_data  = pt;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (NR) @(negedge clk);
    exp_st = enc_part(pt, NR);
    chk("abh_ov", 128'(out_valid), 128'(1));
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("abh_ov0", 128'(out_valid), 128'(0));
    chk("abh_ir", 128'(in_ready), 128'(1));
    chk("abh_cnt", 128'(blk_cnt), 128'(exp_cnt));
    chk("abh_state", rnd_state, exp_st);
  endtask

  task automatic abort_idle();
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = rnd128();
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abi_ir", 128'(in_ready), 128'(1));
    chk("abi_busy", 128'(busy), 128'(0));
    chk("abi_state", rnd_state, exp_st);
  endtask

  task automatic async_rst(input logic [127:0] pt);
    in_valid = 1'b1;
    in_data  = pt;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 16'h0000;
    exp_st  = '0;
    chk("ar_ir", 128'(in_ready), 128'(1));
    chk("ar_busy", 128'(busy), 128'(0));
    chk("ar_ov", 128'(out_valid), 128'(0));
    chk("ar_state", rnd_state, exp_st);
    chk("ar_cnt", 128'(blk_cnt), 128'(exp_cnt));
    chk("ar_key", 128'(key_idx), 128'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fips_key;
    logic [127:0] fips_pt;
    fips_key  = 128'h000102030405060708090a0b0c0d0e0f;
    fips_pt   = 128'h00112233445566778899aabbccddeeff;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    exp_cnt   = 16'h0000;
    exp_st    = '0;
    build_sbox();
    expand(fips_key);
    #12;
    chk("rst_ir", 128'(in_ready), 128'(1));
    chk("rst_ov", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cnt", 128'(blk_cnt), 128'(exp_cnt));
    chk("rst_state", rnd_state, exp_st);
    @(negedge clk);
    rst = 1'b0;

    run_block(fips_pt, 0, 1'b0);
    chk("fips_ct", rnd_state,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    for (int i = 0; i < 3; i++) run_block(rnd128(), 0, 1'b1);
    run_block(rnd128(), 20, 1'b0);

    for (int i = 0; i < 6; i++) begin
      expand(rnd128());
      run_block(rnd128(), int'($urandom_range(0, 3)), 1'b0);
    end

    run_abort(rnd128(), 5);
    run_block(rnd128(), 1, 1'b0);
    abort_hold(rnd128());
    abort_idle();
    run_block(rnd128(), 0, 1'b0);

    async_rst(rnd128());
    run_block(rnd128(), 0, 1'b0);

    force dut.r_blk_cnt = 16'hFFFF;
    #1;
    release dut.r_blk_cnt;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    chk("pre_wrap", 128'(blk_cnt), 128'(exp_cnt));
    run_block(rnd128(), 0, 1'b0);
    chk("wrap", 128'(blk_cnt), 128'(16'h0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of cipher rounds; legal values are 10, 12 and 14.
REQ-002 Port: clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: in_valid  input  1  plaintext block offered.
REQ-005 Port: in_ready  output  1  controller can accept a block.
REQ-006 Port: in_data  input  128  plaintext block.
REQ-007 Port: abort  input  1  synchronous cancel of the current block.
REQ-008 Port: key_idx  output  4  round-key index presented to the external key store.
REQ-009 Port: key_data  input  128  round key for key_idx; combinational, valid in the same cycle.
REQ-010 Port: rnd_state  output  128  state fed to the round datapath (the registered state).
REQ-011 Port: rnd_key  output  128  equals key_data.
REQ-012 Port: rnd_num  output  4  current round number.
REQ-013 Port: rnd_final  output  1  final-round select (skips MixColumns).
REQ-014 Port: rnd_result  input  128  combinational round-datapath output for the current rnd_state/rnd_key.
REQ-015 Port: out_valid  output  1  ciphertext available.
REQ-016 Port: out_ready  input  1  consumer accepts the ciphertext.
REQ-017 Port: out_data  output  128  ciphertext block.
REQ-018 Port: busy  output  1  high in states ROUND and HOLD.
REQ-019 Port: blk_cnt  output  16  count of completed output handshakes.

Function
REQ-020 FSM states SHALL be IDLE, ROUND and HOLD; in_ready = (state==IDLE); out_valid = (state==HOLD).
REQ-021 key_idx SHALL be 0 in IDLE, round_cnt in ROUND, and NR in HOLD.
REQ-022 Accept rule: IDLE and in_valid on a rising edge -> state_reg <= in_data ^ key_data (key 0), round_cnt <= 1, next state ROUND.
REQ-023 ROUND behaviour: each rising edge, state_reg <= rnd_result and round_cnt <= round_cnt+1.
REQ-024 ROUND exit: at the edge where round_cnt==NR, the next state SHALL be HOLD.
REQ-025 rnd_num SHALL equal round_cnt; rnd_final = (state==ROUND && round_cnt==NR).
REQ-026 Latency: out_valid SHALL rise exactly NR cycles after the accept edge; throughput is one block per NR+2 cycles at best.
REQ-027 In HOLD, out_data (= state_reg) SHALL remain stable until the output handshake.
REQ-028 Output handshake: out_valid and out_ready -> next state IDLE and blk_cnt+1 (0xFFFF wraps to 0x0000).
REQ-029 A new block SHALL NOT be accepted in the cycle of the output handshake; in_ready rises one cycle later.
REQ-030 Input while busy: in_valid is ignored while in_ready is low; no block is queued.
REQ-031 abort in ROUND or HOLD SHALL force IDLE at the next edge: no out_valid, blk_cnt unchanged, state_reg unchanged.
REQ-032 abort SHALL take priority over an output handshake in the same cycle.
REQ-033 abort in IDLE SHALL have priority over in_valid (no accept) and is otherwise a no-op.
REQ-034 round_cnt SHALL be 4 bits wide and SHALL never exceed NR.

Reset
REQ-035 While rst is high: state = IDLE, state_reg = 0, round_cnt = 0, blk_cnt = 0, out_valid = 0, busy = 0, in_ready = 1.
REQ-036 rst assertion mid-operation SHALL discard the block immediately without waiting for a clock edge.
REQ-037 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-038 FIPS-197 vector: bench connects the real round datapath and a key-expansion ROM; key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
REQ-039 Back-pressure: out_ready held low 20 cycles -> out_valid and out_data stable throughout, in_ready=0, in_valid ignored, blk_cnt increments by exactly 1 on release.
REQ-040 Round sequencing: monitor during ROUND -> key_idx/rnd_num 1..10 in order, rnd_final high only at round 10.
REQ-041 Abort at round 5 -> IDLE next cycle, no out_valid, blk_cnt unchanged; next block then produces correct ciphertext.
REQ-042 Async reset asserted mid-ROUND between edges -> outputs reach reset values before the next edge.
REQ-043 blk_cnt wrap: preload via 65536 handshakes or force -> 0xFFFF then 0x0000; back-to-back blocks -> accepts spaced 12 cycles apart.
